score_display: RTL
==================

# score_display

Reads the 32-bit binary game score and presents it on the board's eight-digit, common-anode seven-segment display. A sequential double-dabble converter turns each new score into eight BCD digits, and a free-running scanner multiplexes those digits onto the anode and segment pins. Leading zeros are blanked, and the whole display blinks while the game is over. The block sits between the score counter and the top-level display pins.

## Interface
- SCAN_DIV, 17: log2 of clk cycles per digit slot. Full 8-digit refresh takes 2^(SCAN_DIV+3) cycles.
- BLINK_DIV, 25: log2 of the half-period, in clk cycles, of the gameover blink.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Score  input  32  binary score from the score counter; may change at any cycle.
- gameover  input  1  high means the game has ended; the display blinks.
- busy  output  1  high while a conversion is in progress.
- bcd  output  32  last converted value, 8 BCD digits; digit 0 is in bits [3:0].
- AN  output  8  digit anodes, active low; AN[0] is the rightmost digit.
- SEGMENT  output  8  segments {dp,g,f,e,d,c,b,a}, active low.

## Operation
- Converter FSM states: IDLE, CONV, DONE.
- **IDLE**
  - If Score != last, where last is a registered copy of the previously sampled score:
    - load Score into the shift register and into last;
    - clear the 40-bit BCD accumulator and the iteration count;
    - go to CONV.
  - Otherwise stay in IDLE.
- **CONV**
  - Each cycle, add 3 to every accumulator nibble that is >= 5.
  - Then shift {accumulator, shift register} left by 1.
  - After the 32nd iteration, go to DONE.
- **DONE**
  - If accumulator digits 9 or 8 are nonzero (value > 99_999_999), set bcd to 32'h9999_9999 (saturate).
  - Otherwise set bcd to accumulator[31:0].
  - Return to IDLE.
- busy = (state != IDLE).
- Score changes during CONV or DONE are ignored until the FSM is back in IDLE. The next IDLE cycle then compares against last and restarts if needed, so the newest value is always eventually displayed.
- **Scanner**
  - A (SCAN_DIV+3)-bit free-running counter; its top 3 bits select digit d = 0..7.
  - Digit d is blanked (AN all 1) if d > 0 and bcd digits d..7 are all zero. Digit 0 is never blanked.
- **Blink**
  - A BLINK_DIV+1-bit free-running counter.
  - When gameover = 1 and the counter MSB = 1, AN = 8'hFF.
  - When gameover = 0, there is no blanking from blink.
- **Segment codes**, with dp always 1:
  - 0: C0, 1: F9, 2: A4, 3: B0, 4: 99
  - 5: 92, 6: 82, 7: F8, 8: 80, 9: 90
- AN, when not blanked, is all 1 except bit d = 0.

## Timing
- **Reset** (rst_n low, asynchronous):
  - state = IDLE, last = 0, bcd = 0, busy = 0;
  - scan and blink counters = 0;
  - AN = 8'hFF, SEGMENT = 8'hFF.
  - A score of 0 therefore needs no conversion after reset.
- **Conversion latency**
  - Capture edge E0 (IDLE→CONV).
  - Iterations on edges E1..E32; E32 enters DONE.
  - bcd updates and busy falls on edge E33.
  - Latency is 33 cycles from capture to new bcd; busy is high for exactly 33 cycles.
- **Back-to-back conversions**: if Score differs from last at the first IDLE cycle after E33, the next capture occurs at E34.
- **Output registration**: AN and SEGMENT are registered, one cycle behind the scan-counter digit select, and follow bcd changes within 1 cycle. There are no combinational paths from inputs to outputs.
- **Counter wrap**: the scan counter wraps from digit 7 back to digit 0 with no dead slot.
- **Reset mid-conversion**: aborts immediately to the reset values; the partial result is discarded.
- **Simultaneous events**: gameover and a Score change in the same cycle are independent; the conversion proceeds while the display blinks.

## Test plan
- **Reset, then Score = 0**: busy stays 0; with SCAN_DIV = 2, digit 0 shows AN = FE, SEGMENT = C0; AN = FF in every other slot.
- **Score 0 → 12345678**: busy is high 33 cycles after capture; then bcd = 32'h1234_5678. Scanning shows slot 0 SEGMENT = 80 ('8') and slot 7 SEGMENT = F9 ('1').
- **Score = 100_000_000 and 32'hFFFF_FFFF**: bcd = 32'h9999_9999 in both cases; all eight digits show 90.
- **Score changes 5 → 6 at cycle E10 of the 5 conversion**: bcd = 5 at E33, a new capture at E34, bcd = 6 at E67.
- **Score = 40, gameover = 1, BLINK_DIV = 3**: AN = FF for 8 cycles, then normal scanning (FE/FD only, digits 2..7 blanked) for 8 cycles, repeating. After gameover = 0, no blink.
- **Assert rst_n low at E15 of a conversion**: busy = 0 and bcd = 0 immediately, AN = FF; after release with an unchanged nonzero Score, the conversion restarts from E0.

Source files
------------

// File: rtl/score_display.sv
// Score to eight-digit seven-segment display: a sequential double-dabble converter
// feeds a free-running digit scanner with leading-zero blanking and gameover blink.
module score_display #(
   parameter int SCAN_DIV  = 17,
   parameter int BLINK_DIV = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Score,
   input  logic        gameover,
   output logic        busy,
   output logic [31:0] bcd,
   output logic [7:0]  AN,
   output logic [7:0]  SEGMENT
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   localparam int SCAN_W = SCAN_DIV + 3;

   state_t             state, state_nxt;
   logic [31:0]        last;
   logic [31:0]        shift;
   logic [39:0]        acc;
   logic [39:0]        acc_adj;
   logic [4:0]         iter;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [BLINK_DIV:0] blink_cnt;
   logic [2:0]         digit;
   logic [3:0]         nibble;
   logic               blank;
   logic [7:0]         seg_code;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: each always_comb output gets a default first, so no branch can leave it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Score != last) state_nxt = CONV;
         CONV:    if (iter == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 10; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last  <= '0;
         shift <= '0;
         acc   <= '0;
         iter  <= '0;
         bcd   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Score != last) begin
                  last  <= Score;
                  shift <= Score;
                  acc   <= '0;
                  iter  <= '0;
               end
            end
            CONV: begin
               acc   <= {acc_adj[38:0], shift[31]};
               shift <= {shift[30:0], 1'b0};
               iter  <= iter + 5'd1;
            end
            DONE: begin
               // Scores above 99_999_999 need ten digits; the display saturates instead.
               bcd <= (acc[39:32] != 8'h00) ? 32'h9999_9999 : acc[31:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         blink_cnt <= '0;
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      digit  = scan_cnt[SCAN_W-1 -: 3];
      nibble = bcd[{digit, 2'b00} +: 4];
      blank  = (digit != 3'd0) && ((bcd >> {digit, 2'b00}) == 32'd0);
   end

   always_comb begin
      seg_code = 8'hFF;
      case (nibble)
         4'd0: seg_code = 8'hC0;
         4'd1: seg_code = 8'hF9;
         4'd2: seg_code = 8'hA4;
         4'd3: seg_code = 8'hB0;
         4'd4: seg_code = 8'h99;
         4'd5: seg_code = 8'h92;
         4'd6: seg_code = 8'h82;
         4'd7: seg_code = 8'hF8;
         4'd8: seg_code = 8'h80;
         4'd9: seg_code = 8'h90;
         default: seg_code = 8'hFF;
      endcase
   end

   // Pins are registered, so they lag the digit select by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AN      <= 8'hFF;
         SEGMENT <= 8'hFF;
      end else begin
         if (blank || (gameover && blink_cnt[BLINK_DIV])) AN <= 8'hFF;
         else                                              AN <= ~(8'd1 << digit);
         SEGMENT <= seg_code;
      end
   end

endmodule
